vec_length_iter: RTL and testbench

//  Iterative N-dimensional fixed-point vector length unit; successor to the fixed 3-D pipelined length block.

---
 rtl/vec_length_iter.sv | 167 ++++++++++++++++
 tb/tb_vec_length_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_length_iter.sv
// Iterative N-dimensional fixed-point vector length: one squaring multiplier for the
// sum of squares, then a one-bit-per-cycle integer square root (skipped in squared mode).
module vec_length_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 24,
  parameter int N_DIM      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_DIM*DATA_WIDTH-1:0] in_vec,
  input  logic                        in_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_sat,
  output logic                        busy
);

  localparam int ACC_W      = 2*DATA_WIDTH + 2;
  localparam int SQRT_ITERS = DATA_WIDTH + 1;
  localparam int IDX_W      = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam int ITER_W     = $clog2(SQRT_ITERS + 1);
  localparam int REM_W      = DATA_WIDTH + 1;

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N_DIM - 1);
  localparam logic [ITER_W-1:0]     LAST_ITER = ITER_W'(SQRT_ITERS - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACC, SQRT, DONE} state_t;

  state_t                        state_q, state_d;
  logic [N_DIM*DATA_WIDTH-1:0]   vec_q, vec_d;
  logic                          mode_q, mode_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [REM_W-1:0]              rem_q, rem_d;
  logic [DATA_WIDTH-1:0]         root_q, root_d;
  logic [ITER_W-1:0]             iter_q, iter_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;

  logic signed [DATA_WIDTH-1:0]   comp;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_W-1:0]               acc_sum;
  logic                           sq_sat;
  logic [DATA_WIDTH-2:0]          sq_val;
  logic [REM_W+1:0]               rem_sh;
  logic [REM_W+1:0]               trial;
  logic                           take;
  logic [DATA_WIDTH:0]            root_full;
  logic                           sqrt_sat;

  always_comb begin
    comp    = vec_q[DATA_WIDTH-1:0];
    prod    = comp * comp;
    acc_sum = acc_q + ACC_W'($unsigned(prod));
    // Squared result is acc >> FRAC_BITS; any set bit at or above the sign position saturates.
    sq_sat  = |acc_sum[ACC_W-1:FRAC_BITS+DATA_WIDTH-1];
    sq_val  = acc_sum[FRAC_BITS+DATA_WIDTH-2:FRAC_BITS];

    // Digit-by-digit sqrt: bring down the next two radicand bits, try root*4+1.
    rem_sh    = {rem_q, acc_q[ACC_W-1 -: 2]};
    trial     = {1'b0, root_q, 2'b01};
    take      = (rem_sh >= trial);
    root_full = {root_q, take};
    sqrt_sat  = |root_full[DATA_WIDTH:DATA_WIDTH-1];

    state_d     = state_q;
    vec_d       = vec_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    root_d      = root_q;
    iter_d      = iter_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d   = in_vec;
          mode_d  = in_mode;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_sum;
        vec_d = vec_q >> DATA_WIDTH;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          if (mode_q) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_sat_d   = sq_sat;
            out_data_d  = sq_sat ? SAT_MAX : {1'b0, sq_val};
          end else begin
            state_d = SQRT;
            rem_d   = '0;
            root_d  = '0;
            iter_d  = '0;
          end
        end
      end
      SQRT: begin
        acc_d  = acc_q << 2;
        rem_d  = take ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
        root_d = root_full[DATA_WIDTH-1:0];
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sat_d   = sqrt_sat;
          out_data_d  = sqrt_sat ? SAT_MAX : {1'b0, root_full[DATA_WIDTH-2:0]};
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      iter_q      <= iter_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_vec_length_iter.sv
// Bench for vec_length_iter at defaults (Q8.24, 3 components): directed vector table,
// handshake corner sequences, and random vectors against an arithmetic reference model.
module tb_vec_length_iter;

  localparam int DW = 32;
  localparam int FB = 24;
  localparam int ND = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [ND*DW-1:0] in_vec;
  logic            in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sat;
  logic            busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  vec_length_iter #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .N_DIM(ND)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND*DW-1:0] vec;
    bit               mode;
    logic [DW-1:0]    exp_data;
    bit               exp_sat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [ND*DW-1:0] pack3(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [127:0] isqrt(input logic [127:0] s);
    logic [127:0] lo, hi, mid;
    lo = 0;
    hi = 128'h4_0000_0000;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Reference: exact sum of squares, then either truncating shift or floor sqrt.
  task automatic model(input logic [ND*DW-1:0] v, input bit mode,
                       output logic [DW-1:0] d, output bit sat);
    logic [127:0] s, r;
    longint c;
    s = 0;
    for (int i = 0; i < ND; i++) begin
      c = longint'($signed(v[i*DW +: DW]));
      s = s + 128'(c * c);
    end
    r = mode ? (s >> FB) : isqrt(s);
    sat = (r > 128'h7FFF_FFFF);
    d = sat ? 32'h7FFF_FFFF : r[DW-1:0];
  endtask

  task automatic run_vec(input logic [ND*DW-1:0] v, input bit mode,
                         input logic [DW-1:0] ed, input bit es, input int stall,
                         input string name);
    int cnt;
    int lat;
    lat = mode ? ND : ND + DW + 1;
    @(negedge clk);
    chk({name, "_in_ready"}, in_ready, 1'b1);
    in_vec = v;
    in_mode = mode;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec = '0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({name, "_latency"}, cnt, lat);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_sat"}, out_sat, es);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_valid"}, out_valid, 1'b1);
      chk({name, "_hold_data"}, out_data, ed);
      chk({name, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_drop_valid"}, out_valid, 1'b0);
    chk({name, "_back_idle"}, in_ready, 1'b1);
    chk({name, "_out_hold"}, out_data, ed);
  endtask

  vec_t tbl[$];

  initial begin
    logic [ND*DW-1:0] rv;
    logic [DW-1:0]    md;
    bit               ms;
    bit               rm;
    int               cnt;
    int               nvalid;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_vec = '0;
    in_mode = 1'b0;
    out_ready = 1'b1;

    tbl.push_back('{pack3(32'h0300_0000, 32'h0400_0000, 32'h0), 1'b0, 32'h0500_0000, 1'b0});
    tbl.push_back('{pack3(32'h0100_0000, 32'h0100_0000, 32'h0100_0000), 1'b0, 32'h01BB_67AE, 1'b0});
    tbl.push_back('{pack3(32'hFD00_0000, 32'hFC00_0000, 32'h0), 1'b0, 32'h0500_0000, 1'b0});
    tbl.push_back('{pack3(32'h0, 32'h0, 32'h0), 1'b0, 32'h0, 1'b0});
    tbl.push_back('{pack3(32'h0100_0000, 32'h0200_0000, 32'h0200_0000), 1'b1, 32'h0900_0000, 1'b0});
    tbl.push_back('{pack3(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000), 1'b0, 32'h7FFF_FFFF, 1'b1});
    tbl.push_back('{pack3(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000), 1'b1, 32'h7FFF_FFFF, 1'b1});
    tbl.push_back('{pack3(32'h8000_0000, 32'h0, 32'h0), 1'b0, 32'h7FFF_FFFF, 1'b1});
    tbl.push_back('{pack3(32'h8000_0000, 32'h0, 32'h0), 1'b1, 32'h7FFF_FFFF, 1'b1});
    tbl.push_back('{pack3(32'h0000_1000, 32'h0, 32'h0), 1'b1, 32'h0000_0001, 1'b0});
    tbl.push_back('{pack3(32'h0000_0001, 32'h0, 32'h0), 1'b1, 32'h0000_0000, 1'b0});
    tbl.push_back('{pack3(32'h0, 32'h0, 32'hFC00_0000), 1'b0, 32'h0400_0000, 1'b0});

    #12;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_sat", out_sat, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i].vec, tbl[i].mode, tbl[i].exp_data, tbl[i].exp_sat, 0,
                              $sformatf("tbl%0d", i));

    // in_valid held high across a squared-mode transaction: exactly one result
    @(negedge clk);
    in_vec = pack3(32'h0100_0000, 32'h0200_0000, 32'h0200_0000);
    in_mode = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      chk("held_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("held_latency", cnt, ND);
    chk("held_data", out_data, 32'h0900_0000);
    in_valid = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) nvalid++;
    end
    chk("held_extra_results", nvalid, 0);
    chk("held_idle", in_ready, 1'b1);

    // downstream stall of 10 cycles in DONE
    run_vec(pack3(32'h0300_0000, 32'h0400_0000, 32'h0), 1'b0, 32'h0500_0000, 1'b0, 10, "stall");

    // reset mid-SQRT discards the vector
    @(negedge clk);
    in_vec = pack3(32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    in_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) nvalid++;
    end
    chk("midrst_no_output", nvalid, 0);
    run_vec(pack3(32'h0300_0000, 32'h0400_0000, 32'h0), 1'b0, 32'h0500_0000, 1'b0, 0, "post_rst");

    // random vectors vs reference model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < ND; i++)
        rv[i*DW +: DW] = $signed($urandom) >>> $urandom_range(0, 9);
      rm = $urandom_range(0, 1);
      model(rv, rm, md, ms);
      run_vec(rv, rm, md, ms, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
